lock_supervisor: RTL

- Sequencing controller for the 6-digit combination lock datapath.
- Owns the programmable code register and steps through digit entry one digit per strobe.
- Counts failed attempts and enforces a timed lockout after repeated failures.
- Allows the code to be reprogrammed only while the lock is open. Its state code drives the existing HEX decoder path.

---
 rtl/lock_supervisor.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/lock_supervisor.sv
`default_nettype none
// =============================================================================
// Module      : lock_supervisor
// Description : Combination-lock sequencer: digit entry, fail counting with
//               timed lockout, and code reprogramming while open.
// Revision    : 1.0 - initial release
// =============================================================================
module lock_supervisor #(
    parameter int unsigned             DIGITS         = 6,
    parameter int unsigned             MAX_FAILS      = 3,
    parameter int unsigned             LOCKOUT_CYCLES = 16,
    parameter logic [4*DIGITS-1:0]     DEFAULT_CODE   = 24'h432731
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       lock_cmd,
    input  logic       prog_cmd,
    output logic [2:0] state_out,
    output logic [2:0] digit_idx,
    output logic [1:0] fail_cnt,
    output logic       is_open
);

    localparam int unsigned          c_CODE_W    = 4 * DIGITS;
    localparam int unsigned          c_SHADOW_W  = 4 * (DIGITS - 1);
    localparam int unsigned          c_CNT_W     = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0]   c_LOCK_LOAD = c_CNT_W'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]           c_MAX_FAILS = 2'(MAX_FAILS);
    localparam logic [2:0]           c_LAST_IDX  = 3'(DIGITS - 1);

    typedef enum logic [2:0] {
        ST_ENTER   = 3'd0,
        ST_OPEN    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_LOCKOUT = 3'd3,
        ST_PROG    = 3'd4
    } state_t;

    state_t                r_state_q,  w_state_d;
    logic [2:0]            r_idx_q,    w_idx_d;
    logic [1:0]            r_fail_q,   w_fail_d;
    logic                  r_mis_q,    w_mis_d;
    logic                  r_open_q,   w_open_d;
    logic [c_CNT_W-1:0]    r_lock_q,   w_lock_d;
    logic [c_CODE_W-1:0]   r_code_q,   w_code_d;
    logic [c_SHADOW_W-1:0] r_shadow_q, w_shadow_d;

    logic [3:0] w_code_digit;
    logic       w_digit_bad;
    logic       w_cur_mis;
    logic       w_last;

    always_comb begin
        w_code_digit = '0;
        for (int k = 0; k < int'(DIGITS); k++) begin
            if (r_idx_q == 3'(k)) begin
                w_code_digit = r_code_q[c_CODE_W-1-4*k -: 4];
            end
        end
    end

    assign w_digit_bad = (digit_in > 4'd9);
    assign w_cur_mis   = w_digit_bad | (digit_in != w_code_digit);
    assign w_last      = (r_idx_q == c_LAST_IDX);

    always_comb begin
        w_state_d  = r_state_q;
        w_idx_d    = r_idx_q;
        w_fail_d   = r_fail_q;
        w_mis_d    = r_mis_q;
        w_lock_d   = r_lock_q;
        w_code_d   = r_code_q;
        w_shadow_d = r_shadow_q;

        case (r_state_q)
            ST_ENTER: begin
                if (digit_valid) begin
                    if (w_last) begin
                        if (!(r_mis_q | w_cur_mis)) begin
                            w_state_d = ST_OPEN;
                            w_fail_d  = '0;
                            w_mis_d   = 1'b0;
                            w_idx_d   = '0;
                        end else begin
                            w_state_d = ST_FAIL;
                            w_mis_d   = 1'b1;
                            if (r_fail_q != c_MAX_FAILS) begin
                                w_fail_d = r_fail_q + 2'd1;
                            end
                        end
                    end else begin
                        w_mis_d = r_mis_q | w_cur_mis;
                        w_idx_d = r_idx_q + 3'd1;
                    end
                end
            end
            ST_FAIL: begin
                if (r_fail_q == c_MAX_FAILS) begin
                    w_state_d = ST_LOCKOUT;
                    w_lock_d  = c_LOCK_LOAD;
                end else begin
                    w_state_d = ST_ENTER;
                    w_mis_d   = 1'b0;
                    w_idx_d   = '0;
                end
            end
            ST_LOCKOUT: begin
                if (r_lock_q == '0) begin
                    w_state_d = ST_ENTER;
                    w_fail_d  = '0;
                    w_mis_d   = 1'b0;
                    w_idx_d   = '0;
                end else begin
                    w_lock_d = r_lock_q - c_CNT_W'(1);
                end
            end
            ST_OPEN: begin
                // lock_cmd has priority over prog_cmd
                if (lock_cmd) begin
                    w_state_d = ST_ENTER;
                    w_idx_d   = '0;
                    w_mis_d   = 1'b0;
                end else if (prog_cmd) begin
                    w_state_d = ST_PROG;
                    w_idx_d   = '0;
                end
            end
            ST_PROG: begin
                if (digit_valid) begin
                    if (w_digit_bad) begin
                        w_state_d = ST_OPEN;
                        w_idx_d   = '0;
                    end else if (w_last) begin
                        w_code_d  = {r_shadow_q, digit_in};
                        w_state_d = ST_OPEN;
                        w_idx_d   = '0;
                    end else begin
                        for (int k = 0; k < int'(DIGITS) - 1; k++) begin
                            if (r_idx_q == 3'(k)) begin
                                w_shadow_d[c_SHADOW_W-1-4*k -: 4] = digit_in;
                            end
                        end
                        w_idx_d = r_idx_q + 3'd1;
                    end
                end
            end
            default: begin
                w_state_d = ST_ENTER;
                w_idx_d   = '0;
            end
        endcase

        w_open_d = (w_state_d == ST_OPEN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q  <= ST_ENTER;
            r_idx_q    <= '0;
            r_fail_q   <= '0;
            r_mis_q    <= 1'b0;
            r_open_q   <= 1'b0;
            r_lock_q   <= '0;
            r_code_q   <= DEFAULT_CODE;
            r_shadow_q <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_idx_q    <= w_idx_d;
            r_fail_q   <= w_fail_d;
            r_mis_q    <= w_mis_d;
            r_open_q   <= w_open_d;
            r_lock_q   <= w_lock_d;
            r_code_q   <= w_code_d;
            r_shadow_q <= w_shadow_d;
        end
    end

    assign state_out = r_state_q;
    assign digit_idx = r_idx_q;
    assign fail_cnt  = r_fail_q;
    assign is_open   = r_open_q;

endmodule
`default_nettype wire
